// File: rtl/sm_twi_pkg.sv
// Shared op codes, FSM states and quarter indices for the TWI master.
package sm_twi_pkg;

  typedef enum logic [1:0] {
    TWI_OP_START = 2'b00,
    TWI_OP_WRITE = 2'b01,
    TWI_OP_READ  = 2'b10,
    TWI_OP_STOP  = 2'b11
  } twi_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP
  } twi_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/sm_twi_qtick.sv
// Quarter-period timer: CLK_DIV cycles per quarter, Q0..Q3 index, frozen while SCL is stretched.
module sm_twi_qtick
  import sm_twi_pkg::*;
#(
  parameter int CLK_DIV = 125,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       stretch_hold,
  output logic [1:0] q,
  output logic       q_end
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic             primed;

  assign q_end = run && primed && !stretch_hold && (cnt == CNT_LAST);

  // One setup cycle after leaving IDLE gives the accept-to-done latency its +1.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt    <= '0;
      q      <= Q0;
      primed <= 1'b0;
    end else if (!primed) begin
      primed <= 1'b1;
    end else if (!stretch_hold) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        q   <= q + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm_twi_master.sv
// Byte-level I2C master: START/WRITE/READ/STOP sequencing with clock stretching and arbitration.
module sm_twi_master
  import sm_twi_pkg::*;
#(
  parameter int CLK_DIV = 125,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rx_ack,
  output logic       arb_lost,
  output logic       busy,
  output logic       bus_busy,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o
);

  twi_state_e state;
  twi_op_e    op;
  logic [3:0] bit_cnt;
  logic [7:0] sh;
  logic       ack_l;
  logic [1:0] scl_sync, sda_sync, scl_o_dly;
  logic       scl_s, sda_s;
  logic [1:0] q;
  logic       q_end, hold, arb_hit;

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
  assign busy  = !cmd_ready;

  // scl_o is delayed by the synchronizer depth so our own release is not mistaken for a stretch.
  assign hold = (state != ST_IDLE) && (q == Q1) && scl_o_dly[1] && !scl_s;

  assign arb_hit = q_end && !sda_s &&
                   (((state == ST_START) && (q == Q1)) ||
                    ((state == ST_BIT) && (op == TWI_OP_WRITE) && (q == Q2) &&
                     (bit_cnt != 4'd0) && sda_o));

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_o_dly <= 2'b11;
    end else begin
      scl_sync  <= {scl_sync[0], scl_i};
      sda_sync  <= {sda_sync[0], sda_i};
      scl_o_dly <= {scl_o_dly[0], scl_o};
    end
  end

  sm_twi_qtick #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_qtick (
    .clk          (clk),
    .rst          (rst),
    .run          (state != ST_IDLE),
    .stretch_hold (hold),
    .q            (q),
    .q_end        (q_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op        <= TWI_OP_START;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      rd_data   <= 8'h00;
      rx_ack    <= 1'b0;
      arb_lost  <= 1'b0;
      bus_busy  <= 1'b0;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      bit_cnt   <= 4'd0;
      sh        <= 8'h00;
      ack_l     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (arb_hit) begin
        scl_o     <= 1'b1;
        sda_o     <= 1'b1;
        arb_lost  <= 1'b1;
        done      <= 1'b1;
        bus_busy  <= 1'b0;
        cmd_ready <= 1'b1;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (cmd_valid) begin
            op        <= twi_op_e'(cmd_op);
            ack_l     <= cmd_ack;
            sh        <= cmd_data;
            bit_cnt   <= 4'd8;
            arb_lost  <= 1'b0;
            cmd_ready <= 1'b0;
            case (twi_op_e'(cmd_op))
              TWI_OP_START: begin state <= ST_START; sda_o <= 1'b1;        end
              TWI_OP_WRITE: begin state <= ST_BIT;   sda_o <= cmd_data[7]; end
              TWI_OP_READ:  begin state <= ST_BIT;   sda_o <= 1'b1;        end
              default:      begin state <= ST_STOP;  sda_o <= 1'b0;        end
            endcase
          end
          ST_START: if (q_end) begin
            case (q)
              Q0:      scl_o <= 1'b1;
              Q1:      sda_o <= 1'b0;
              Q2:      scl_o <= 1'b0;
              default: begin
                bus_busy  <= 1'b1;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                state     <= ST_IDLE;
              end
            endcase
          end
          ST_BIT: if (q_end) begin
            case (q)
              Q0: scl_o <= 1'b1;
              Q1: ;
              Q2: begin
                scl_o <= 1'b0;
                if (bit_cnt == 4'd0) begin
                  if (op == TWI_OP_WRITE) rx_ack <= sda_s;
                end else if (op == TWI_OP_READ) begin
                  sh <= {sh[6:0], sda_s};
                end
              end
              default: begin
                if (bit_cnt == 4'd0) begin
                  if (op == TWI_OP_READ) rd_data <= sh;
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
                end else begin
                  bit_cnt <= bit_cnt - 4'd1;
                  // Slot 9 releases SDA on WRITE and drives the requested ACK/NACK on READ.
                  if (op == TWI_OP_WRITE) begin
                    sh    <= {sh[6:0], 1'b1};
                    sda_o <= (bit_cnt == 4'd1) ? 1'b1 : sh[6];
                  end else begin
                    sda_o <= (bit_cnt == 4'd1) ? ack_l : 1'b1;
                  end
                end
              end
            endcase
          end
          ST_STOP: if (q_end) begin
            case (q)
              Q0:      scl_o <= 1'b1;
              Q1:      sda_o <= 1'b1;
              Q2:      ;
              default: begin
                bus_busy  <= 1'b0;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                state     <= ST_IDLE;
              end
            endcase
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_twi_master.sv
// Bench for sm_twi_master: wired-AND bus, behavioural I2C slave, directed and random byte transfers.
module tb_sm_twi_master;

  localparam int CLK_DIV = 4;
  localparam int T_SS    = 4 * CLK_DIV + 1;
  localparam int T_BYTE  = 36 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ack;
  logic       done;
  logic [7:0] rd_data;
  logic       rx_ack;
  logic       arb_lost;
  logic       busy;
  logic       bus_busy;
  logic       scl_i, scl_o, sda_i, sda_o;
  logic       slave_scl = 1'b1;
  logic       slave_sda = 1'b1;

  assign scl_i = scl_o & slave_scl;
  assign sda_i = sda_o & slave_sda;

  always #5 clk = ~clk;

  sm_twi_master #(.CLK_DIV(CLK_DIV), .DIV_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ack   (cmd_ack),
    .done      (done),
    .rd_data   (rd_data),
    .rx_ack    (rx_ack),
    .arb_lost  (arb_lost),
    .busy      (busy),
    .bus_busy  (bus_busy),
    .scl_i     (scl_i),
    .scl_o     (scl_o),
    .sda_i     (sda_i),
    .sda_o     (sda_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Arm requests from the main sequence; the slave process picks them up on its next negedge.
  logic       arm_tok = 1'b0;
  logic       arm_en = 1'b0;
  logic [8:0] bits_req = 9'h1FF;
  int         stretch_req = -1;

  // Slave/monitor state: bits[8] is slot 1, bits[0] is slot 9.
  logic       arm_seen = 1'b0;
  logic       armed = 1'b0;
  logic [8:0] bits = 9'h1FF;
  logic [8:0] obs_v = 9'h0;
  int         rise_cnt = 0;
  int         stretch_at = -1;
  int         stretch_cnt = 0;
  logic       slot9_low = 1'b0;
  logic       start_seen = 1'b0;
  logic       stop_seen = 1'b0;

  initial begin
    logic s, d, prev_s, prev_d, prev_scl_o;
    logic [8:0] b;
    prev_s = 1'b1; prev_d = 1'b1; prev_scl_o = 1'b1;
    forever begin
      @(negedge clk);
      if (arm_tok != arm_seen) begin
        arm_seen    = arm_tok;
        armed       = arm_en;
        bits        = bits_req;
        rise_cnt    = 0;
        obs_v       = 9'h0;
        stretch_at  = stretch_req;
        stretch_cnt = 0;
        slot9_low   = 1'b0;
        start_seen  = 1'b0;
        stop_seen   = 1'b0;
        slave_sda   = arm_en ? bits_req[8] : 1'b1;
      end
      if (stretch_cnt > 0) begin
        stretch_cnt--;
        if (stretch_cnt == 0) slave_scl = 1'b1;
      end
      if (stretch_at >= 0 && rise_cnt == stretch_at && scl_o && !prev_scl_o) begin
        slave_scl   = 1'b0;
        stretch_cnt = 20;
        stretch_at  = -1;
      end
      s = scl_o & slave_scl;
      d = sda_o & slave_sda;
      if (s && prev_s && prev_d && !d) start_seen = 1'b1;
      if (s && prev_s && !prev_d && d) stop_seen = 1'b1;
      if (s && !prev_s) begin
        obs_v = {obs_v[7:0], d};
        rise_cnt++;
      end
      if (!s && prev_s && armed) begin
        b = bits << rise_cnt;
        slave_sda = (rise_cnt < 9) ? b[8] : 1'b1;
      end
      if (armed && rise_cnt >= 8 && !sda_o) slot9_low = 1'b1;
      prev_s = s; prev_d = d; prev_scl_o = scl_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic arm(input logic en, input logic [8:0] b, input int stretch_slot);
    arm_en      = en;
    bits_req    = b;
    stretch_req = stretch_slot;
    arm_tok     = ~arm_tok;
    repeat (2) @(negedge clk);
  endtask

  // Issues one command and returns cycles from the accept edge to the done edge (-1 on timeout).
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack,
                        input bit pulse, output int lat);
    int w;
    @(negedge clk);
    cmd_op = op; cmd_data = data; cmd_ack = ack; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      if (pulse && c == 5) begin cmd_op = 2'b00; cmd_valid = 1'b1; end
      if (pulse && c == 6) cmd_valid = 1'b0;
      if (done) begin lat = c; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, w, n_done, n_busy;
    logic [7:0] dat;
    logic ack;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; cmd_ack = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_scl_o", scl_o, 1);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rx_ack", rx_ack, 0);
    chk("rst_arb", arb_lost, 0);
    chk("rst_bus_busy", bus_busy, 0);
    @(negedge clk); rst = 1'b0;

    // START then WRITE 0xA4 with ACK
    arm(1'b0, 9'h1FF, -1);
    do_cmd(2'b00, 8'h00, 1'b1, 1'b0, lat);
    chk("start_lat", lat, T_SS);
    chk("start_cond", start_seen, 1);
    chk("start_bus_busy", bus_busy, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    arm(1'b1, {8'hFF, 1'b0}, -1);
    do_cmd(2'b01, 8'hA4, 1'b1, 1'b0, lat);
    chk("wr_lat", lat, T_BYTE);
    chk("wr_bits", obs_v, {8'hA4, 1'b0});
    chk("wr_rx_ack", rx_ack, 0);
    chk("wr_bus_busy", bus_busy, 1);

    // READ 0x5C, NACK from master
    arm(1'b1, {8'h5C, 1'b1}, -1);
    do_cmd(2'b10, 8'h00, 1'b1, 1'b0, lat);
    chk("rd_lat", lat, T_BYTE);
    chk("rd_data", rd_data, 8'h5C);
    chk("rd_slot9_sda_o", slot9_low, 0);
    chk("rd_bits", obs_v, {8'h5C, 1'b1});

    // WRITE 0x3C with a 20-cycle stretch in slot 3
    arm(1'b1, {8'hFF, 1'b0}, 2);
    do_cmd(2'b01, 8'h3C, 1'b1, 1'b0, lat);
    chk("stretch_lat", lat, T_BYTE + 20);
    chk("stretch_bits", obs_v, {8'h3C, 1'b0});
    chk("stretch_rx_ack", rx_ack, 0);
    chk("rd_data_held", rd_data, 8'h5C);

    // Random bytes against the slave model
    for (int i = 0; i < 8; i++) begin
      dat = 8'($urandom);
      ack = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        arm(1'b1, {8'hFF, ack}, -1);
        do_cmd(2'b01, dat, 1'b1, 1'b0, lat);
        chk("rnd_wr_lat", lat, T_BYTE);
        chk("rnd_wr_bits", obs_v, {dat, ack});
        chk("rnd_wr_rx_ack", rx_ack, ack);
      end else begin
        arm(1'b1, {dat, 1'b1}, -1);
        do_cmd(2'b10, 8'h00, ack, 1'b0, lat);
        chk("rnd_rd_lat", lat, T_BYTE);
        chk("rnd_rd_data", rd_data, dat);
        chk("rnd_rd_bits", obs_v, {dat, ack});
        chk("rnd_rd_slot9", slot9_low, !ack);
      end
    end

    // STOP with a cmd_valid pulse while busy
    arm(1'b0, 9'h1FF, -1);
    do_cmd(2'b11, 8'h00, 1'b1, 1'b1, lat);
    chk("stop_lat", lat, T_SS);
    chk("stop_cond", stop_seen, 1);
    chk("stop_bus_busy", bus_busy, 0);
    n_busy = 0;
    repeat (40) begin @(posedge clk); #1; if (!cmd_ready) n_busy++; end
    chk("busy_pulse_ignored", n_busy, 0);

    // Arbitration lost in slot 2 of WRITE 0xFF
    do_cmd(2'b00, 8'h00, 1'b1, 1'b0, lat);
    chk("start2_lat", lat, T_SS);
    arm(1'b1, 9'b1_0111_1111, -1);
    do_cmd(2'b01, 8'hFF, 1'b1, 1'b0, lat);
    chk("arb_lat", lat, 4 * CLK_DIV + 3 * CLK_DIV + 1);
    chk("arb_lost", arb_lost, 1);
    chk("arb_scl_o", scl_o, 1);
    chk("arb_sda_o", sda_o, 1);
    chk("arb_ready", cmd_ready, 1);
    chk("arb_bus_busy", bus_busy, 0);
    arm(1'b0, 9'h1FF, -1);
    repeat (10) @(posedge clk);

    // Reset in the middle of a WRITE, then a fresh START
    do_cmd(2'b00, 8'h00, 1'b1, 1'b0, lat);
    chk("start3_lat", lat, T_SS);
    chk("arb_cleared", arb_lost, 0);
    arm(1'b1, 9'h1FF, -1);
    @(negedge clk);
    cmd_op = 2'b01; cmd_data = 8'h96; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("wr_accepted", busy, 1);
    w = 0;
    while (rise_cnt < 4 && w < 2000) begin @(posedge clk); w++; end
    chk("reach_slot5", w < 2000, 1);
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_done = done ? 1 : 0;
    chk("rst_mid_scl_o", scl_o, 1);
    chk("rst_mid_sda_o", sda_o, 1);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done) n_done++; end
    chk("rst_mid_no_done", n_done, 0);
    arm(1'b0, 9'h1FF, -1);
    do_cmd(2'b00, 8'h00, 1'b1, 1'b0, lat);
    chk("post_rst_start_lat", lat, T_SS);
    chk("post_rst_bus_busy", bus_busy, 1);
    do_cmd(2'b11, 8'h00, 1'b1, 1'b0, lat);
    chk("final_stop_lat", lat, T_SS);
    chk("final_bus_busy", bus_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
